// File: rtl/vga_tile_map.sv
// Tile-map RAM (COLS x ROWS x DW) with a registered video read port, CPU write port and a
// fill / row-collapse engine that owns the write port while it runs.
module vga_tile_map #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int DW   = 4,
  parameter int AW   = 12,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [RW-1:0] cmd_row,
  input  logic [DW-1:0] cmd_data,
  output logic          busy,
  output logic          done
);

  localparam int N  = COLS * ROWS;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] OP_FILL     = 2'd0;
  localparam logic [1:0] OP_COLLAPSE = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [1:0]    r_op;
  logic [DW-1:0] r_data;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [N];

  logic          w_accept;
  logic          w_row_ok;
  logic [AW-1:0] w_collapse_ptr;
  logic          w_from_above;
  logic [NW-1:0] w_src_idx;
  logic [DW-1:0] w_eng_dat;
  logic          w_eng_we;
  logic          w_cpu_we;
  logic          w_we;
  logic [NW-1:0] w_widx;
  logic [DW-1:0] w_wdat;
  logic          w_rd_ok;

  assign w_accept       = cmd_valid && (r_state == S_IDLE);
  assign w_row_ok       = 32'(cmd_row) < 32'(ROWS);
  assign w_collapse_ptr = AW'((32'(cmd_row) + 32'd1) * 32'(COLS) - 32'd1);

  // Descending pointer: the source cell one row up is always read before it is overwritten.
  assign w_from_above = (r_op == OP_COLLAPSE) && (32'(r_ptr) >= 32'(COLS));
  assign w_src_idx    = NW'(r_ptr - AW'(COLS));
  assign w_eng_dat    = w_from_above ? r_mem[w_src_idx] : r_data;

  // A reset edge during RUN performs no write, so the abort point is exact.
  assign w_eng_we = (r_state == S_RUN) && !rst;
  assign w_cpu_we = (r_state != S_RUN) && wen && (32'(waddr) < 32'(N));
  assign w_we     = w_eng_we || w_cpu_we;
  assign w_widx   = w_eng_we ? NW'(r_ptr) : NW'(waddr);
  assign w_wdat   = w_eng_we ? w_eng_dat : wdata;
  assign w_rd_ok  = 32'(raddr) < 32'(N);

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_widx] <= w_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (ren) begin
      r_rdata <= w_rd_ok ? r_mem[NW'(raddr)] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_op    <= OP_FILL;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            if (cmd_op == OP_FILL) begin
              r_ptr   <= AW'(N - 1);
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else if (cmd_op == OP_COLLAPSE && w_row_ok) begin
              r_ptr   <= w_collapse_ptr;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (r_ptr == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr <= r_ptr - 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_vga_tile_map.sv
// Scoreboard bench for vga_tile_map: default 40x30x4 instance plus an 8x4x8 variant.
module tb_vga_tile_map;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wen, ren, cmd_valid, cmd_ready, busy, done;
  logic [11:0] waddr, raddr;
  logic [3:0]  wdata, rdata, cmd_data;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_row;

  logic        s_wen, s_ren, s_cmd_valid, s_cmd_ready, s_busy, s_done;
  logic [4:0]  s_waddr, s_raddr;
  logic [7:0]  s_wdata, s_rdata, s_cmd_data;
  logic [1:0]  s_cmd_op;
  logic [1:0]  s_cmd_row;

  vga_tile_map dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data), .busy(busy), .done(done)
  );

  vga_tile_map #(.COLS(8), .ROWS(4), .DW(8), .AW(5)) dut_s (
    .clk(clk), .rst(rst), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata),
    .ren(s_ren), .raddr(s_raddr), .rdata(s_rdata),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
    .cmd_row(s_cmd_row), .cmd_data(s_cmd_data), .busy(s_busy), .done(s_done)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mdl [2][1200];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ncols(input bit s); return s ? 8 : 40; endfunction
  function automatic int nrows(input bit s); return s ? 4 : 30; endfunction
  function automatic logic [7:0] dmask(input bit s); return s ? 8'hFF : 8'h0F; endfunction
  function automatic logic get_busy(input bit s); return s ? s_busy : busy; endfunction
  function automatic logic get_done(input bit s); return s ? s_done : done; endfunction
  function automatic logic get_ready(input bit s); return s ? s_cmd_ready : cmd_ready; endfunction
  function automatic logic [7:0] get_rdata(input bit s); return s ? s_rdata : {4'h0, rdata}; endfunction

  task automatic set_wr(input bit s, input logic en, input int addr, input int data);
    if (s) begin s_wen = en; s_waddr = addr[4:0]; s_wdata = data[7:0]; end
    else   begin wen = en;   waddr = addr[11:0];  wdata = data[3:0];   end
  endtask

  task automatic set_rd(input bit s, input logic en, input int addr);
    if (s) begin s_ren = en; s_raddr = addr[4:0]; end
    else   begin ren = en;   raddr = addr[11:0];  end
  endtask

  task automatic set_cmd(input bit s, input logic v, input int op, input int row, input int data);
    if (s) begin s_cmd_valid = v; s_cmd_op = op[1:0]; s_cmd_row = row[1:0]; s_cmd_data = data[7:0]; end
    else   begin cmd_valid = v;   cmd_op = op[1:0];   cmd_row = row[4:0];   cmd_data = data[3:0];   end
  endtask

  // Issues reads lo..hi back to back; each expectation is queued at issue, checked a cycle later.
  task automatic rd_burst(input bit s, input int lo, input int hi, input string tag);
    int n;
    logic [7:0] e;
    n = ncols(s) * nrows(s);
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      if (a > lo) begin
        e = exp_q.pop_front();
        check(tag, get_rdata(s), e);
      end
      if (a <= hi) begin
        set_rd(s, 1'b1, a);
        exp_q.push_back((a < n) ? mdl[s][a] : 8'h00);
      end else begin
        set_rd(s, 1'b0, 0);
      end
    end
  endtask

  task automatic preload(input bit s);
    int c;
    c = ncols(s);
    for (int a = 0; a < c * nrows(s); a++) begin
      @(negedge clk);
      set_wr(s, 1'b1, a, ((a / c) + (a % c)) & 15);
      mdl[s][a] = 8'(((a / c) + (a % c)) & 15);
    end
    @(negedge clk);
    set_wr(s, 1'b0, 0, 0);
  endtask

  task automatic run_cmd(input bit s, input int op, input int row, input int data,
                         input int exp_w, input bit poke, input string tag);
    int cyc, guard, c;
    c = ncols(s);
    @(negedge clk);
    check({tag, "_ready"}, get_ready(s), 1);
    set_cmd(s, 1'b1, op, row, data);
    @(negedge clk);
    set_cmd(s, 1'b0, 0, 0, ~data);
    cyc = 0;
    guard = 0;
    while (!get_done(s) && guard < 3000) begin
      if (get_busy(s)) cyc++;
      if (poke) set_wr(s, guard == 10, 5, 1);
      @(negedge clk);
      guard++;
    end
    set_wr(s, 1'b0, 0, 0);
    check({tag, "_done"}, get_done(s), 1);
    check({tag, "_busy_cycles"}, cyc, exp_w);
    check({tag, "_busy_low"}, get_busy(s), 0);
    @(negedge clk);
    check({tag, "_done_once"}, get_done(s), 0);
    check({tag, "_ready_back"}, get_ready(s), 1);
    if (op == 0) begin
      for (int a = 0; a < c * nrows(s); a++) mdl[s][a] = 8'(data) & dmask(s);
    end else if (op == 1 && row < nrows(s)) begin
      for (int r = row; r >= 1; r--)
        for (int k = 0; k < c; k++) mdl[s][r * c + k] = mdl[s][(r - 1) * c + k];
      for (int k = 0; k < c; k++) mdl[s][k] = 8'(data) & dmask(s);
    end
  endtask

  initial begin
    int dcnt;
    rst = 1'b1;
    set_wr(0, 0, 0, 0); set_rd(0, 0, 0); set_cmd(0, 0, 0, 0, 0);
    set_wr(1, 0, 0, 0); set_rd(1, 0, 0); set_cmd(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", s_cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", cmd_ready, 1);

    run_cmd(0, 0, 0, 4'hA, 1200, 1'b1, "fill_a");
    rd_burst(0, 0, 1200, "fill_a_rd");

    preload(0);
    run_cmd(0, 1, 29, 0, 1200, 1'b0, "coll29");
    rd_burst(0, 0, 1199, "coll29_rd");

    preload(0);
    run_cmd(0, 1, 10, 5, 440, 1'b0, "coll10");
    rd_burst(0, 0, 1199, "coll10_rd");

    run_cmd(0, 1, 0, 7, 40, 1'b0, "coll0");
    run_cmd(0, 1, 30, 9, 0, 1'b0, "bad_row");
    run_cmd(0, 2, 3, 9, 0, 1'b0, "bad_op2");
    run_cmd(0, 3, 3, 9, 0, 1'b0, "bad_op3");
    rd_burst(0, 0, 1200, "after_bad_rd");

    @(negedge clk);
    set_cmd(0, 1'b1, 0, 0, 3);
    @(negedge clk);
    set_cmd(0, 1'b0, 0, 0, 0);
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst = 1'b1;
    set_rd(0, 1'b1, 1199);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 0);
    check("abort_ready", cmd_ready, 0);
    rst = 1'b0;
    set_rd(0, 1'b0, 0);
    @(negedge clk);
    if (done) dcnt++;
    check("abort_no_done", dcnt, 0);
    for (int a = 1100; a < 1200; a++) mdl[0][a] = 8'h03;
    rd_burst(0, 0, 1200, "abort_rd");

    run_cmd(1, 0, 0, 8'hC3, 32, 1'b0, "s_fill");
    rd_burst(1, 0, 31, "s_fill_rd");
    preload(1);
    run_cmd(1, 1, 2, 8'h5A, 24, 1'b0, "s_coll2");
    rd_burst(1, 0, 31, "s_coll2_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
